// File: rtl/crc_frame_receiver.sv
// crc_frame_receiver
//   Parses framed bytes from a UART receiver: SOF_BYTE, LEN, LEN payload bytes, CRC-8.
//   Payload bytes are forwarded one cycle after their strobe; a single-cycle frame_done
//   strobe reports the end of every frame (good, CRC error, bad length or inter-byte timeout).
//
// Parameters
//   SOF_BYTE        start-of-frame marker
//   MAX_LEN         largest legal payload length in bytes (1..255)
//   TIMEOUT_CYCLES  longest silence tolerated between bytes inside a frame (>= 2)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   rx_data     received byte, qualified by rx_valid (single-cycle strobe, no backpressure)
//   pay_data    payload byte, qualified by pay_valid
//   frame_done  single-cycle end-of-frame / abort strobe
//   frame_ok    result of the last frame, held until the next frame_done
//   err_code    00 none, 01 CRC mismatch, 10 bad length, 11 timeout (held like frame_ok)
//   busy        high while a frame is in progress
module crc_frame_receiver #(
  parameter logic [7:0]  SOF_BYTE       = 8'hA5,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] pay_data,
  output logic       pay_valid,
  output logic       frame_done,
  output logic       frame_ok,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int unsigned TmoW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  MaxLen = 8'(MAX_LEN);

  localparam logic [1:0] ErrNone = 2'b00;
  localparam logic [1:0] ErrCrc  = 2'b01;
  localparam logic [1:0] ErrLen  = 2'b10;
  localparam logic [1:0] ErrTmo  = 2'b11;

  typedef enum logic [1:0] {StIdle, StLen, StData, StCrc} state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      crc_q, crc_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [7:0]      pay_data_q, pay_data_d;
  logic            pay_valid_q, pay_valid_d;
  logic            done_q, done_d;
  logic            ok_q, ok_d;
  logic [1:0]      err_q, err_d;

  logic [7:0] crc_next;
  logic       len_bad;
  logic       tmo_fire;

  // CRC-8, polynomial x^8+x^2+x+1, MSB first, one whole byte per call.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign crc_next = crc8_byte(crc_q, rx_data);
  assign len_bad  = rx_data > MaxLen;
  // The counter would reach TIMEOUT_CYCLES at this edge; an arriving byte wins.
  assign tmo_fire = (state_q != StIdle) && !rx_valid &&
                    (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      crc_q       <= '0;
      tmo_q       <= '0;
      pay_data_q  <= '0;
      pay_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= ErrNone;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      tmo_q       <= tmo_d;
      pay_data_q  <= pay_data_d;
      pay_valid_q <= pay_valid_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
    end
  end

  // Next state, length counter, CRC accumulator and timeout counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    unique case (state_q)
      StIdle: begin
        if (rx_valid && (rx_data == SOF_BYTE)) begin
          state_d = StLen;
          crc_d   = '0;
        end
      end
      StLen: begin
        if (rx_valid) begin
          crc_d = crc_next;
          if (rx_data == 8'h00) begin
            state_d = StCrc;
          end else if (len_bad) begin
            state_d = StIdle;
          end else begin
            cnt_d   = rx_data;
            state_d = StData;
          end
        end else if (tmo_fire) begin
          state_d = StIdle;
        end
      end
      StData: begin
        if (rx_valid) begin
          crc_d = crc_next;
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = StCrc;
          end
        end else if (tmo_fire) begin
          state_d = StIdle;
        end
      end
      StCrc: begin
        if (rx_valid || tmo_fire) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Cleared by every accepted byte and whenever the frame is (or becomes) idle.
    if ((state_d == StIdle) || rx_valid) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  // Registered outputs: next values, plus busy
  always_comb begin
    pay_data_d  = pay_data_q;
    pay_valid_d = 1'b0;
    done_d      = 1'b0;
    ok_d        = ok_q;
    err_d       = err_q;
    unique case (state_q)
      StIdle: ;
      StLen: begin
        if (rx_valid) begin
          if (len_bad) begin
            done_d = 1'b1;
            ok_d   = 1'b0;
            err_d  = ErrLen;
          end
        end else if (tmo_fire) begin
          done_d = 1'b1;
          ok_d   = 1'b0;
          err_d  = ErrTmo;
        end
      end
      StData: begin
        if (rx_valid) begin
          pay_valid_d = 1'b1;
          pay_data_d  = rx_data;
        end else if (tmo_fire) begin
          done_d = 1'b1;
          ok_d   = 1'b0;
          err_d  = ErrTmo;
        end
      end
      StCrc: begin
        if (rx_valid) begin
          done_d = 1'b1;
          ok_d   = (rx_data == crc_q);
          err_d  = (rx_data == crc_q) ? ErrNone : ErrCrc;
        end else if (tmo_fire) begin
          done_d = 1'b1;
          ok_d   = 1'b0;
          err_d  = ErrTmo;
        end
      end
      default: ;
    endcase
    busy = (state_q != StIdle);
  end

  assign pay_data   = pay_data_q;
  assign pay_valid  = pay_valid_q;
  assign frame_done = done_q;
  assign frame_ok   = ok_q;
  assign err_code   = err_q;

endmodule

// File: tb/tb_crc_frame_receiver.sv
// Self-checking bench for crc_frame_receiver: directed vectors, timeout boundary,
// back-to-back frames, mid-frame reset and randomized frames against a frame-level model.
module tb_crc_frame_receiver;

  localparam logic [7:0]  Sof       = 8'hA5;
  localparam int unsigned MaxLen    = 16;
  localparam int unsigned TmoCycles = 8;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       frame_done;
  logic       frame_ok;
  logic [1:0] err_code;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc_frame_receiver #(
    .SOF_BYTE      (Sof),
    .MAX_LEN       (MaxLen),
    .TIMEOUT_CYCLES(TmoCycles)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .pay_data  (pay_data),
    .pay_valid (pay_valid),
    .frame_done(frame_done),
    .frame_ok  (frame_ok),
    .err_code  (err_code),
    .busy      (busy)
  );

  // Observed events, stamped with the cycle in which they are visible.
  logic [7:0] obs_pay_data[$];
  int         obs_pay_cyc[$];
  int         obs_done_cyc[$];
  logic       obs_done_ok[$];
  logic [1:0] obs_done_err[$];
  logic       obs_done_busy[$];
  bit         overlap_seen;

  always @(negedge clk) begin
    if (pay_valid === 1'b1) begin
      obs_pay_data.push_back(pay_data);
      obs_pay_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      obs_done_cyc.push_back(cyc);
      obs_done_ok.push_back(frame_ok);
      obs_done_err.push_back(err_code);
      obs_done_busy.push_back(busy);
    end
    if ((pay_valid === 1'b1) && (frame_done === 1'b1)) overlap_seen = 1'b1;
  end

  // Reference CRC: remainder of (message * x^8) divided by x^8+x^2+x+1 over GF(2).
  function automatic logic [7:0] crc_ref(input byte_q_t msg);
    bit         m[$];
    logic [8:0] poly;
    logic [7:0] r;
    poly = 9'h107;
    foreach (msg[i]) for (int b = 7; b >= 0; b--) m.push_back(msg[i][b]);
    for (int k = 0; k < 8; k++) m.push_back(1'b0);
    for (int i = 0; i + 8 < m.size(); i++) begin
      if (m[i]) for (int j = 0; j < 9; j++) m[i+j] = m[i+j] ^ poly[8-j];
    end
    for (int j = 0; j < 8; j++) r[7-j] = m[m.size() - 8 + j];
    return r;
  endfunction

  task automatic clear_obs();
    obs_pay_data.delete();
    obs_pay_cyc.delete();
    obs_done_cyc.delete();
    obs_done_ok.delete();
    obs_done_err.delete();
    obs_done_busy.delete();
    overlap_seen = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits gap idle cycles, then strobes one byte; stamp is the cycle that samples it.
  task automatic send_byte(input logic [7:0] b, input int gap, output int stamp);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    stamp    = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    checks += 6;
    if (pay_data !== 8'h00) begin errors++; $display("FAIL reset_pay_data: got %0h expected 0", pay_data); end
    if (pay_valid !== 1'b0) begin errors++; $display("FAIL reset_pay_valid: got %0b expected 0", pay_valid); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %0b expected 0", frame_done); end
    if (frame_ok !== 1'b0) begin errors++; $display("FAIL reset_frame_ok: got %0b expected 0", frame_ok); end
    if (err_code !== 2'b00) begin errors++; $display("FAIL reset_err_code: got %0b expected 00", err_code); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_vectors();
    logic [7:0] v[4][4];
    int         vn[4];
    int         exp_pay[4];
    logic       exp_ok[4];
    logic [1:0] exp_err[4];
    int         s;
    v[0] = '{8'hA5, 8'h01, 8'h00, 8'h15}; vn[0] = 4; exp_pay[0] = 1; exp_ok[0] = 1; exp_err[0] = 2'b00;
    v[1] = '{8'hA5, 8'h00, 8'h00, 8'h00}; vn[1] = 3; exp_pay[1] = 0; exp_ok[1] = 1; exp_err[1] = 2'b00;
    v[2] = '{8'hA5, 8'h01, 8'h00, 8'h14}; vn[2] = 4; exp_pay[2] = 1; exp_ok[2] = 0; exp_err[2] = 2'b01;
    v[3] = '{8'hA5, 8'h11, 8'h00, 8'h00}; vn[3] = 2; exp_pay[3] = 0; exp_ok[3] = 0; exp_err[3] = 2'b10;
    for (int t = 0; t < 4; t++) begin
      clear_obs();
      for (int i = 0; i < vn[t]; i++) send_byte(v[t][i], 0, s);
      idle(TmoCycles + 4);
      checks++;
      if (obs_pay_data.size() !== exp_pay[t]) begin
        errors++; $display("FAIL vec%0d_pay_count: got %0d expected %0d", t, obs_pay_data.size(), exp_pay[t]);
      end else if (exp_pay[t] == 1) begin
        checks++;
        if (obs_pay_data[0] !== 8'h00) begin errors++; $display("FAIL vec%0d_pay_data: got %0h expected 0", t, obs_pay_data[0]); end
      end
      checks++;
      if (obs_done_cyc.size() !== 1) begin
        errors++; $display("FAIL vec%0d_done_count: got %0d expected 1", t, obs_done_cyc.size());
      end else begin
        checks += 4;
        if (obs_done_cyc[0] !== s + 1) begin errors++; $display("FAIL vec%0d_done_cycle: got %0d expected %0d", t, obs_done_cyc[0], s + 1); end
        if (obs_done_ok[0] !== exp_ok[t]) begin errors++; $display("FAIL vec%0d_frame_ok: got %0b expected %0b", t, obs_done_ok[0], exp_ok[t]); end
        if (obs_done_err[0] !== exp_err[t]) begin errors++; $display("FAIL vec%0d_err_code: got %0b expected %0b", t, obs_done_err[0], exp_err[t]); end
        if (obs_done_busy[0] !== 1'b0) begin errors++; $display("FAIL vec%0d_busy_at_done: got %0b expected 0", t, obs_done_busy[0]); end
      end
    end
  endtask

  task automatic test_timeout();
    int      s;
    byte_q_t body;
    // Silence after a partial payload.
    clear_obs();
    send_byte(Sof, 0, s);
    send_byte(8'h02, 0, s);
    send_byte(8'hAA, 0, s);
    idle(TmoCycles + 4);
    checks += 2;
    if (obs_pay_data.size() !== 1) begin errors++; $display("FAIL tmo_pay_count: got %0d expected 1", obs_pay_data.size()); end
    if (obs_done_cyc.size() !== 1) begin
      errors++; $display("FAIL tmo_done_count: got %0d expected 1", obs_done_cyc.size());
    end else begin
      checks += 3;
      if (obs_done_cyc[0] !== s + TmoCycles + 1) begin
        errors++; $display("FAIL tmo_done_cycle: got %0d expected %0d", obs_done_cyc[0], s + TmoCycles + 1);
      end
      if (obs_done_ok[0] !== 1'b0) begin errors++; $display("FAIL tmo_frame_ok: got %0b expected 0", obs_done_ok[0]); end
      if (obs_done_err[0] !== 2'b11) begin errors++; $display("FAIL tmo_err_code: got %0b expected 11", obs_done_err[0]); end
    end
    // Bytes landing exactly on the last tolerated idle cycle keep the frame alive.
    clear_obs();
    body = '{8'h02, 8'hAA, 8'hBB};
    send_byte(Sof, 0, s);
    send_byte(8'h02, 0, s);
    send_byte(8'hAA, 0, s);
    send_byte(8'hBB, TmoCycles - 1, s);
    send_byte(crc_ref(body), TmoCycles - 1, s);
    idle(TmoCycles + 4);
    checks += 2;
    if (obs_pay_data.size() !== 2) begin errors++; $display("FAIL edge_pay_count: got %0d expected 2", obs_pay_data.size()); end
    if (obs_done_cyc.size() !== 1) begin
      errors++; $display("FAIL edge_done_count: got %0d expected 1", obs_done_cyc.size());
    end else begin
      checks += 3;
      if (obs_done_cyc[0] !== s + 1) begin errors++; $display("FAIL edge_done_cycle: got %0d expected %0d", obs_done_cyc[0], s + 1); end
      if (obs_done_ok[0] !== 1'b1) begin errors++; $display("FAIL edge_frame_ok: got %0b expected 1", obs_done_ok[0]); end
      if (obs_done_err[0] !== 2'b00) begin errors++; $display("FAIL edge_err_code: got %0b expected 00", obs_done_err[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int      st[7];
    byte_q_t body;
    logic [7:0] fr[7];
    body = '{8'h01, 8'h5A};
    fr = '{Sof, 8'h00, 8'h00, Sof, 8'h01, 8'h5A, 8'h00};
    fr[6] = crc_ref(body);
    clear_obs();
    // Second SOF is sampled in the cycle where the first frame_done is high.
    for (int i = 0; i < 7; i++) send_byte(fr[i], 0, st[i]);
    idle(TmoCycles + 4);
    checks += 2;
    if (obs_done_cyc.size() !== 2) begin
      errors++; $display("FAIL b2b_done_count: got %0d expected 2", obs_done_cyc.size());
    end else begin
      checks += 4;
      if (obs_done_cyc[0] !== st[2] + 1) begin errors++; $display("FAIL b2b_done0_cycle: got %0d expected %0d", obs_done_cyc[0], st[2] + 1); end
      if (obs_done_cyc[1] !== st[6] + 1) begin errors++; $display("FAIL b2b_done1_cycle: got %0d expected %0d", obs_done_cyc[1], st[6] + 1); end
      if (obs_done_ok[1] !== 1'b1) begin errors++; $display("FAIL b2b_frame_ok: got %0b expected 1", obs_done_ok[1]); end
      if (obs_done_err[1] !== 2'b00) begin errors++; $display("FAIL b2b_err_code: got %0b expected 00", obs_done_err[1]); end
    end
    if (obs_pay_data.size() !== 1) begin
      errors++; $display("FAIL b2b_pay_count: got %0d expected 1", obs_pay_data.size());
    end else begin
      checks += 2;
      if (obs_pay_data[0] !== 8'h5A) begin errors++; $display("FAIL b2b_pay_data: got %0h expected 5a", obs_pay_data[0]); end
      if (obs_pay_cyc[0] !== st[5] + 1) begin errors++; $display("FAIL b2b_pay_cycle: got %0d expected %0d", obs_pay_cyc[0], st[5] + 1); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int s;
    clear_obs();
    send_byte(Sof, 0, s);
    send_byte(8'h03, 0, s);
    send_byte(8'hAA, 0, s);
    reset = 1'b1;
    #1;
    checks += 6;
    if (pay_data !== 8'h00) begin errors++; $display("FAIL midrst_pay_data: got %0h expected 0", pay_data); end
    if (pay_valid !== 1'b0) begin errors++; $display("FAIL midrst_pay_valid: got %0b expected 0", pay_valid); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL midrst_frame_done: got %0b expected 0", frame_done); end
    if (frame_ok !== 1'b0) begin errors++; $display("FAIL midrst_frame_ok: got %0b expected 0", frame_ok); end
    if (err_code !== 2'b00) begin errors++; $display("FAIL midrst_err_code: got %0b expected 00", err_code); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    idle(TmoCycles + 4);
    checks++;
    if (obs_done_cyc.size() !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", obs_done_cyc.size()); end
    clear_obs();
    send_byte(Sof, 0, s);
    send_byte(8'h00, 0, s);
    send_byte(8'h00, 0, s);
    idle(4);
    checks++;
    if (obs_done_cyc.size() !== 1 || obs_done_ok[0] !== 1'b1) begin
      errors++; $display("FAIL midrst_next_frame: got %0d done events expected 1 with frame_ok=1", obs_done_cyc.size());
    end
  endtask

  // kind: 0 good, 1 CRC error, 2 bad length, 3 truncated (timeout)
  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      int         kind, len, nsend, pay_exp, done_exp, s, gap, n;
      byte_q_t    body;
      logic [7:0] fr[$];
      int         st[$];
      logic [7:0] crc, g;
      kind = $urandom_range(0, 3);
      len  = (kind == 2) ? $urandom_range(MaxLen + 1, 255) : $urandom_range(0, MaxLen);
      body.push_back(8'(len));
      if (kind != 2) for (int i = 0; i < len; i++) begin
        body.push_back(($urandom_range(0, 3) == 0) ? Sof : 8'($urandom));
      end
      crc = crc_ref(body);
      if (kind == 1) crc = crc ^ 8'($urandom_range(1, 255));
      fr.push_back(Sof);
      foreach (body[i]) fr.push_back(body[i]);
      if (kind != 2) fr.push_back(crc);
      nsend = (kind == 3) ? $urandom_range(1, len + 2) : fr.size();
      clear_obs();
      if ($urandom_range(0, 2) == 0) begin
        g = 8'($urandom);
        if (g == Sof) g = ~Sof;
        send_byte(g, $urandom_range(0, 3), s);
      end
      for (int i = 0; i < nsend; i++) begin
        if (i == 0) gap = $urandom_range(0, 3);
        else gap = ($urandom_range(0, 3) == 0) ? TmoCycles - 1 : $urandom_range(0, TmoCycles - 1);
        send_byte(fr[i], gap, s);
        st.push_back(s);
      end
      idle(TmoCycles + 4);
      pay_exp  = (kind == 2) ? 0 : (kind == 3) ? ((nsend >= 2) ? nsend - 2 : 0) : len;
      done_exp = (kind == 3) ? st[nsend-1] + TmoCycles + 1 : (kind == 2) ? st[1] + 1 : st[len+2] + 1;
      checks += 3;
      if (obs_pay_data.size() !== pay_exp) begin
        errors++; $display("FAIL rnd%0d_pay_count: got %0d expected %0d", f, obs_pay_data.size(), pay_exp);
      end
      if (overlap_seen !== 1'b0) begin errors++; $display("FAIL rnd%0d_pay_done_overlap: got 1 expected 0", f); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_busy_after: got %0b expected 0", f, busy); end
      n = (obs_pay_data.size() < pay_exp) ? obs_pay_data.size() : pay_exp;
      for (int i = 0; i < n; i++) begin
        checks += 2;
        if (obs_pay_data[i] !== fr[2+i]) begin
          errors++; $display("FAIL rnd%0d_pay%0d_data: got %0h expected %0h", f, i, obs_pay_data[i], fr[2+i]);
        end
        if (obs_pay_cyc[i] !== st[2+i] + 1) begin
          errors++; $display("FAIL rnd%0d_pay%0d_cycle: got %0d expected %0d", f, i, obs_pay_cyc[i], st[2+i] + 1);
        end
      end
      checks++;
      if (obs_done_cyc.size() !== 1) begin
        errors++; $display("FAIL rnd%0d_done_count: got %0d expected 1", f, obs_done_cyc.size());
      end else begin
        checks += 5;
        if (obs_done_cyc[0] !== done_exp) begin
          errors++; $display("FAIL rnd%0d_done_cycle: got %0d expected %0d", f, obs_done_cyc[0], done_exp);
        end
        if (obs_done_ok[0] !== (kind == 0)) begin
          errors++; $display("FAIL rnd%0d_frame_ok: got %0b expected %0b", f, obs_done_ok[0], kind == 0);
        end
        if (obs_done_err[0] !== 2'(kind)) begin
          errors++; $display("FAIL rnd%0d_err_code: got %0d expected %0d", f, obs_done_err[0], kind);
        end
        if (frame_ok !== (kind == 0)) begin
          errors++; $display("FAIL rnd%0d_ok_held: got %0b expected %0b", f, frame_ok, kind == 0);
        end
        if (err_code !== 2'(kind)) begin
          errors++; $display("FAIL rnd%0d_err_held: got %0d expected %0d", f, err_code, kind);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_timeout();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
